// File: rtl/regfile_mp.sv
// -----------------------------------------------------------------------------
// regfile_mp -- parametrised multi-port register file
//
// NRD registered read ports, two write ports (port 1 wins on a same-address
// write), optional hardwired-zero location 0 and a clear sequencer that
// sweeps the array to zero after reset or on request. `ready` is low while
// the sweep runs; accesses are ignored and read data is forced to zero.
//
// Build option:
//   REGFILE_BYPASS_EN  defined   : write-first, a read that matches an
//                                  effective write on the same edge returns
//                                  the written data (port 1 wins).
//                      undefined : read-first, same-edge reads return the
//                                  previous contents.
//
// Parameters:
//   XLEN      data width
//   NREGS     number of registers (power of two, >= 2)
//   NRD       number of read ports (1..4)
//   ZERO_REG  1 = location 0 reads 0 and ignores writes
//   AW        address width, derived from NREGS
//
// Ports:
//   clk          clock, rising edge
//   rst_n        asynchronous active-low reset
//   clr          synchronous request to re-clear the whole array
//   rs           read addresses, port p at [p*AW +: AW]
//   rd_data      registered read data, port p at [p*XLEN +: XLEN]
//   we0/wa0/wd0  write port 0
//   we1/wa1/wd1  write port 1 (priority)
//   ready        array cleared and accepting accesses
//   wr_conflict  both ports wrote the same effective address last cycle
// -----------------------------------------------------------------------------
module regfile_mp #(
    parameter  int XLEN     = 32,
    parameter  int NREGS    = 32,
    parameter  int NRD      = 2,
    parameter  int ZERO_REG = 1,
    localparam int AW       = $clog2(NREGS)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clr,
    input  logic [NRD*AW-1:0]    rs,
    output logic [NRD*XLEN-1:0]  rd_data,
    input  logic                 we0,
    input  logic                 we1,
    input  logic [AW-1:0]        wa0,
    input  logic [AW-1:0]        wa1,
    input  logic [XLEN-1:0]      wd0,
    input  logic [XLEN-1:0]      wd1,
    output logic                 ready,
    output logic                 wr_conflict
);

    typedef enum logic {
        S_CLEAR = 1'b0,
        S_RUN   = 1'b1
    } state_e;

    localparam logic [AW-1:0] LAST_IDX = AW'(NREGS - 1);

    state_e              state_q, state_d;
    logic [AW-1:0]       idx_q, idx_d;
    logic                ready_q, ready_d;
    logic                wr_conflict_q, wr_conflict_d;
    logic [NRD*XLEN-1:0] rd_data_q;
    logic [XLEN-1:0]     rd_val [NRD];
    logic [XLEN-1:0]     regs [NREGS];

    logic run;
    logic eff0, eff1;

    assign run  = (state_q == S_RUN);

    // A write is effective only with its enable set and, when location 0 is
    // hardwired, a non-zero address.
    assign eff0 = we0 && !((ZERO_REG != 0) && (wa0 == '0));
    assign eff1 = we1 && !((ZERO_REG != 0) && (wa1 == '0));

    // ------------------------------------------------------------------
    // Clear sequencer
    // ------------------------------------------------------------------
    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // leaves it unassigned (which would infer a latch).
        state_d = state_q;
        idx_d   = idx_q;
        ready_d = 1'b0;
        unique case (state_q)
            S_CLEAR: begin
                idx_d = idx_q + 1'b1;
                if (idx_q == LAST_IDX) begin
                    state_d = S_RUN;
                    idx_d   = '0;
                    ready_d = 1'b1;
                end
            end
            S_RUN: begin
                ready_d = 1'b1;
                if (clr) begin
                    state_d = S_CLEAR;
                    idx_d   = '0;
                    ready_d = 1'b0;
                end
            end
            default: begin
                state_d = S_CLEAR;
                idx_d   = '0;
            end
        endcase
    end

    assign wr_conflict_d = run && eff0 && eff1 && (wa0 == wa1);

    // ------------------------------------------------------------------
    // Read path, one mux per port
    // ------------------------------------------------------------------
    for (genvar p = 0; p < NRD; p++) begin : g_rd
        logic [AW-1:0] ra;
        assign ra = rs[p*AW +: AW];

        always_comb begin
            rd_val[p] = regs[ra];
`ifdef REGFILE_BYPASS_EN
            if (eff1 && (wa1 == ra)) begin
                rd_val[p] = wd1;
            end else if (eff0 && (wa0 == ra)) begin
                rd_val[p] = wd0;
            end
`endif
            if ((ZERO_REG != 0) && (ra == '0)) begin
                rd_val[p] = '0;
            end
            if (!run) begin
                rd_val[p] = '0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Control and output registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_CLEAR;
            idx_q         <= '0;
            ready_q       <= 1'b0;
            wr_conflict_q <= 1'b0;
            rd_data_q     <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples the pre-edge values, independent of order.
            state_q       <= state_d;
            idx_q         <= idx_d;
            ready_q       <= ready_d;
            wr_conflict_q <= wr_conflict_d;
            for (int p = 0; p < NRD; p++) begin
                rd_data_q[p*XLEN +: XLEN] <= rd_val[p];
            end
        end
    end

    // ------------------------------------------------------------------
    // Storage array
    // ------------------------------------------------------------------
    // NOTE: the array is deliberately left out of the reset; the sweep is
    // what initialises it, which keeps it mappable to plain flops/RAM.
    always_ff @(posedge clk) begin
        if (!run) begin
            regs[idx_q] <= '0;
        end else begin
            if (eff0 && !(eff1 && (wa1 == wa0))) begin
                regs[wa0] <= wd0;
            end
            if (eff1) begin
                regs[wa1] <= wd1;
            end
        end
    end

    assign rd_data     = rd_data_q;
    assign ready       = ready_q;
    assign wr_conflict = wr_conflict_q;

endmodule

// File: tb/tb_regfile_mp.sv
// -----------------------------------------------------------------------------
// tb_regfile_mp -- self-checking bench for regfile_mp
//
// A driver applies one set of inputs per cycle (just after the falling edge)
// and pushes the response a reference model predicts for the following
// rising edge into a queue. A monitor pops one entry at every falling edge
// and compares it against the DUT outputs.
//
// The model keeps the array as a plain array and the clear sequencer as a
// count of remaining sweep edges. Define REGFILE_BYPASS_EN for both the
// bench and the RTL to check the write-first build.
// -----------------------------------------------------------------------------
module tb_regfile_mp;

    localparam int XLEN     = 32;
    localparam int NREGS    = 32;
    localparam int NRD      = 2;
    localparam int ZERO_REG = 1;
    localparam int AW       = $clog2(NREGS);

    logic                clk;
    logic                rst_n;
    logic                clr;
    logic [NRD*AW-1:0]   rs;
    logic [NRD*XLEN-1:0] rd_data;
    logic                we0, we1;
    logic [AW-1:0]       wa0, wa1;
    logic [XLEN-1:0]     wd0, wd1;
    logic                ready;
    logic                wr_conflict;

    regfile_mp #(
        .XLEN     (XLEN),
        .NREGS    (NREGS),
        .NRD      (NRD),
        .ZERO_REG (ZERO_REG)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .clr         (clr),
        .rs          (rs),
        .rd_data     (rd_data),
        .we0         (we0),
        .we1         (we1),
        .wa0         (wa0),
        .wa1         (wa1),
        .wd0         (wd0),
        .wd1         (wd1),
        .ready       (ready),
        .wr_conflict (wr_conflict)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [NRD*XLEN-1:0] rd;
        logic                rdy;
        logic                conf;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    // Reference state
    logic [XLEN-1:0] mem [NREGS];
    int              sweep_left = NREGS;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    // Predict the outputs after the next rising edge from the inputs now applied.
    task automatic model_edge();
        exp_t            e;
        bit              e0, e1;
        logic [AW-1:0]   a;
        logic [XLEN-1:0] v;
        e = '0;
        if (!rst_n) begin
            sweep_left = NREGS;
        end else if (sweep_left > 0) begin
            mem[NREGS - sweep_left] = '0;
            sweep_left--;
            e.rdy = (sweep_left == 0);
        end else begin
            e0 = we0 && !(ZERO_REG != 0 && wa0 == 0);
            e1 = we1 && !(ZERO_REG != 0 && wa1 == 0);
            for (int p = 0; p < NRD; p++) begin
                a = rs[p*AW +: AW];
                v = mem[a];
`ifdef REGFILE_BYPASS_EN
                if (e1 && wa1 == a)      v = wd1;
                else if (e0 && wa0 == a) v = wd0;
`endif
                if (ZERO_REG != 0 && a == 0) v = '0;
                e.rd[p*XLEN +: XLEN] = v;
            end
            e.conf = e0 && e1 && (wa0 == wa1);
            if (e0) mem[wa0] = wd0;
            if (e1) mem[wa1] = wd1;
            if (clr) begin
                sweep_left = NREGS;
                e.rdy      = 1'b0;
            end else begin
                e.rdy = 1'b1;
            end
        end
        exp_q.push_back(e);
    endtask

    // One cycle of stimulus.
    task automatic cyc(input bit r, input bit c,
                       input bit w0, input int a0, input logic [XLEN-1:0] d0,
                       input bit w1, input int a1, input logic [XLEN-1:0] d1,
                       input int r0, input int r1);
        @(negedge clk);
        #1;
        rst_n = r;
        clr   = c;
        we0   = w0;
        wa0   = AW'(a0);
        wd0   = d0;
        we1   = w1;
        wa1   = AW'(a1);
        wd1   = d1;
        rs    = {AW'(r1), AW'(r0)};
        model_edge();
    endtask

    task automatic idle(input int n, input int r0, input int r1);
        for (int i = 0; i < n; i++) cyc(1, 0, 0, 0, 0, 0, 0, 0, r0, r1);
    endtask

    task automatic read_all();
        for (int i = 0; i < NREGS; i += 2) cyc(1, 0, 0, 0, 0, 0, 0, 0, i, i + 1);
    endtask

    // Monitor: one expected entry per rising edge, compared mid-cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("rd_data", 64'(rd_data), 64'(e.rd));
                check("ready", 64'(ready), 64'(e.rdy));
                check("wr_conflict", 64'(wr_conflict), 64'(e.conf));
            end
        end
    end

    initial begin
        int waited;
        for (int i = 0; i < NREGS; i++) mem[i] = '0;
        rst_n = 1'b0;
        clr   = 1'b0;
        we0   = 1'b0;
        we1   = 1'b0;
        wa0   = '0;
        wa1   = '0;
        wd0   = '0;
        wd1   = '0;
        rs    = '0;

        // Reset held, then the power-up sweep; ready must rise on edge NREGS.
        for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        idle(NREGS + 2, 1, 2);
        read_all();

        // Hardwired zero location.
        cyc(1, 0, 1, 0, 32'hDEADBEEF, 0, 0, 0, 0, 0);
        idle(2, 0, 0);

        // Dual write, different addresses.
        cyc(1, 0, 1, 5, 32'h11, 1, 6, 32'h22, 0, 0);
        idle(2, 5, 6);

        // Dual write, same address: port 1 stored, one-cycle conflict flag.
        cyc(1, 0, 1, 7, 32'hAA, 1, 7, 32'hBB, 0, 0);
        idle(3, 7, 7);

        // Same-edge read/write of x3 (currently 0).
        cyc(1, 0, 1, 3, 32'h1234, 0, 0, 0, 3, 0);
        idle(2, 3, 3);

        // Fill x1..x31, request a clear, write during the sweep, read back.
        for (int i = 1; i < NREGS; i += 2) begin
            cyc(1, 0, 1, i, $urandom | 32'h1, (i + 1 < NREGS), (i + 1) % NREGS,
                $urandom | 32'h1, i, i + 1);
        end
        read_all();
        cyc(1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < NREGS; i++) begin
            cyc(1, 0, 1, $urandom_range(1, NREGS - 1), $urandom, 1,
                $urandom_range(1, NREGS - 1), $urandom,
                $urandom_range(0, NREGS - 1), $urandom_range(0, NREGS - 1));
        end
        read_all();

        // Reset in the middle of a sweep (at idx 10), then a full restart.
        cyc(1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        idle(10, 4, 9);
        for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 0, 0, 0, 0, 4, 9);
        idle(NREGS + 2, 4, 9);
        read_all();

        // Randomised traffic on a narrow address window to force conflicts
        // and same-edge hits, with occasional clear requests.
        for (int i = 0; i < 600; i++) begin
            cyc(1, ($urandom_range(0, 59) == 0),
                $urandom_range(0, 1), $urandom_range(0, 7), $urandom,
                $urandom_range(0, 1), $urandom_range(0, 7), $urandom,
                $urandom_range(0, 7),
                ($urandom_range(0, 3) == 0) ? $urandom_range(0, NREGS - 1)
                                            : $urandom_range(0, 7));
        end
        idle(NREGS + 2, 1, 2);
        read_all();

        // Drain the scoreboard with a bounded wait.
        waited = 0;
        while (exp_q.size() > 0 && waited < 10) begin
            @(negedge clk);
            waited++;
        end
        #2;
        if (exp_q.size() > 0) begin
            checks++;
            failures++;
            $display("FAIL drain: got %0d pending expected 0 pending", exp_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-port register file for the core datapath, replacing the fixed 32×32, 2-read/1-write file. Provides NRD registered read ports and two write ports with fixed priority. Location 0 can be hardwired to zero. A clear sequencer zeroes the array after reset or on request and holds `ready` low until clearing is done. Sits between decode (read addresses) and writeback (write ports).

## Interface
- `XLEN`, 32, data width in bits
- `NREGS`, 32, number of registers; power of two, ≥ 2
- `NRD`, 2, number of read ports, 1..4
- `ZERO_REG`, 1, 1 = location 0 reads 0 and ignores writes
- `AW`, $clog2(NREGS), address width; derived, not overridden

- `clk` in 1: single clock, rising edge
- `rst_n` in 1: reset, asynchronous, active-low
- `clr` in 1: synchronous request to re-clear the whole array
- `rs` in NRD*AW: read addresses; port p at bits [p*AW +: AW]
- `rd_data` out NRD*XLEN: registered read data; port p at bits [p*XLEN +: XLEN]
- `we0`, `we1` in 1: write enables; port 1 has priority
- `wa0`, `wa1` in AW: write addresses
- `wd0`, `wd1` in XLEN: write data
- `ready` out 1: array cleared and accepting accesses
- `wr_conflict` out 1: registered; 1 when both ports wrote the same effective address in the previous cycle

## Operation
- **States**
  - CLEAR: per cycle, write 0 to `regs[idx]` and increment `idx`.
    - In the cycle with `idx == NREGS-1`, go to RUN.
  - RUN: normal access.
    - `clr == 1` sampled in RUN: go to CLEAR with `idx = 0`.
    - `clr` in CLEAR: ignored; the current sweep continues.
- **Reset**
  - `rst_n` low forces CLEAR, `idx = 0`, `ready = 0`, `rd_data = 0`, `wr_conflict = 0`, at any time, including mid-sweep.
  - The array itself has no reset; it is initialised only by the sweep.
- **Writes in CLEAR**: ignored. `rd_data` is 0 on every port.
- **Writes in RUN**
  - An address is effective when its enable is 1 and, with `ZERO_REG = 1`, the address is non-zero.
  - Both ports effective with different addresses: both written.
  - Both ports effective with the same address: `wd1` is stored and `wr_conflict` is 1 next cycle.
- **Reads in RUN**
  - On each edge, `rd_data[p] <= regs[rs[p]]`, subject to bypass (see Configuration).
  - `ZERO_REG = 1` and `rs[p] == 0`: `rd_data[p] = 0`.
- Address width is exact (power-of-two depth), so no out-of-range addresses exist.

## Timing
- Read latency is 1 cycle: address applied before edge N, data valid after edge N, held until the next edge.
- A write is committed at the edge where it is sampled. A read issued in the following cycle returns the new data.
- **Sweep length**
  - After `rst_n` rises, `ready` goes to 1 after exactly NREGS rising edges.
  - For `clr` sampled at edge N, `ready` drops after edge N and returns to 1 after edge N+NREGS.
- `ready` and `wr_conflict` are registered outputs.

## Configuration
- `REGFILE_BYPASS_EN`, defined (write-first):
  - If a read address matches an effective write address on the same edge, `rd_data[p]` returns the written data.
  - Port 1 wins on a double match.
- `REGFILE_BYPASS_EN`, undefined (read-first): same-edge reads return the previous contents.
- In CLEAR, `rd_data` is 0 either way.

## Test plan
- **Reset sweep**: release `rst_n` with NREGS = 32. `ready` = 0 for 32 edges, then 1. Reading every address returns 0x00000000.
- **Zero register**: `we0 = 1`, `wa0 = 0`, `wd0 = 0xDEADBEEF`, then read `rs[0] = 0`. Returns 0. `wr_conflict` stays 0.
- **Dual write**
  - Different addresses: write 0x11 to x5 on port 0 and 0x22 to x6 on port 1. A later read returns x5 = 0x11 and x6 = 0x22.
  - Same address: write x7 on both ports with 0xAA and 0xBB. Read returns 0xBB; `wr_conflict` = 1 for exactly one cycle.
- **Same-edge read/write**: write x3 = 0x1234 while `rs[0] = 3` and x3 previously 0x0.
  - With `REGFILE_BYPASS_EN`: `rd_data[0]` = 0x1234.
  - Without it: `rd_data[0]` = 0x0, then 0x1234 next cycle.
- **Clear request**: fill x1..x31 with non-zero values, then pulse `clr`.
  - `ready` is 0 for 32 cycles and writes during the sweep are dropped.
  - After the sweep, every register reads 0.
- **Reset mid-sweep**: assert `rst_n` low at `idx = 10`, release after 3 cycles. The sweep restarts at `idx = 0` and `ready` rises exactly 32 edges after release.
